// File: rtl/tap_tempo_div.sv
`default_nettype none
// ============================================================================
//  Module   : tap_tempo_div
//  Purpose  : Measures the interval between taps on a tempo button and turns
//             it into the 12-bit divisor for the downstream variable clock
//             divider. Includes a 2-flop synchroniser, lockout debounce,
//             timeout back to idle, and hold-last-divisor when idle.
//  Ports    : clk        - system clock
//             reset      - asynchronous, active-high reset
//             tap_in     - raw button level, asynchronous to clk
//             div_clock  - current divisor in measurement ticks (registered)
//             div_valid  - one-cycle pulse on every accepted measurement
//             tap_seen   - one-cycle pulse on every accepted tap
//             locked     - high while a measured tempo is in force
//  Options  : TAP_AVG_EN - when defined, each new divisor is the average of
//             the previous and current measurement (first one after idle is
//             taken directly).
//  Revision : 1.0 - initial release
// ============================================================================
module tap_tempo_div #(
  parameter int          PRESCALE      = 256,
  parameter int          LOCKOUT_TICKS = 4,
  parameter logic [11:0] MIN_DIV       = 12'd2,
  parameter logic [11:0] DEFAULT_DIV   = 12'd500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tap_in,
  output logic [11:0] div_clock,
  output logic        div_valid,
  output logic        tap_seen,
  output logic        locked
);

  localparam int               PRE_W       = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(PRESCALE - 1);
  localparam int               LK_W        = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
  localparam logic [LK_W-1:0]  LK_LOAD     = LK_W'(LOCKOUT_TICKS);
  localparam logic [11:0]      CNT_MAX     = 12'hFFF;
  localparam logic [11:0]      CNT_TIMEOUT = 12'hFFE;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Registered state
  logic             s1_q, s2_q, s3_q;
  logic             s1_d, s2_d, s3_d;
  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [LK_W-1:0]  lockout_cnt_q, lockout_cnt_d;
  logic [11:0]      int_cnt_q, int_cnt_d;
  logic [11:0]      div_clock_q, div_clock_d;
  logic             div_valid_q, div_valid_d;
  logic             tap_seen_q, tap_seen_d;
  logic             locked_q, locked_d;
`ifdef TAP_AVG_EN
  logic [11:0]      prev_meas_q, prev_meas_d;
  logic             have_prev_q, have_prev_d;
`endif

  // Combinational decode
  logic        rise;
  logic        tick;
  logic        acc;
  logic [12:0] meas_raw;
  logic [11:0] meas;
  logic        start;     // accepted tap while idle
  logic        take;      // accepted tap that produces a measurement
  logic        acc_eff;   // tap that actually restarts the counters
  logic        timeout;
  logic [11:0] new_div;

  always_comb begin
    s1_d = tap_in;
    s2_d = s1_q;
    s3_d = s2_q;

    rise = s2_q & ~s3_q;
    tick = (pre_cnt_q == PRE_LAST);
    acc  = rise & (lockout_cnt_q == '0);

    // A tick coinciding with the tap is counted in the measurement.
    meas_raw = {1'b0, int_cnt_q} + {12'b0, tick};
    meas     = meas_raw[12] ? CNT_MAX : meas_raw[11:0];

    start   = acc && (state_q == ST_IDLE);
    // Too-short intervals in MEASURE are dropped without side effects.
    take    = acc && (state_q == ST_MEASURE) && (meas >= MIN_DIV);
    acc_eff = start | take;
    // A tap landing on the timeout tick wins and measures 4095.
    timeout = (state_q == ST_MEASURE) && tick && (int_cnt_q == CNT_TIMEOUT) && !take;

`ifdef TAP_AVG_EN
    new_div = have_prev_q ? 12'(({1'b0, prev_meas_q} + {1'b0, meas}) >> 1) : meas;
`else
    new_div = meas;
`endif

    // Prescaler
    if (acc_eff || tick) pre_cnt_d = '0;
    else                 pre_cnt_d = pre_cnt_q + 1'b1;

    // Lockout
    if (acc_eff)                             lockout_cnt_d = LK_LOAD;
    else if (tick && (lockout_cnt_q != '0))  lockout_cnt_d = lockout_cnt_q - 1'b1;
    else                                     lockout_cnt_d = lockout_cnt_q;

    // Interval counter, saturating
    if (acc_eff)                             int_cnt_d = '0;
    else if (tick && (int_cnt_q != CNT_MAX)) int_cnt_d = int_cnt_q + 1'b1;
    else                                     int_cnt_d = int_cnt_q;

    // State and outputs
    state_d     = state_q;
    div_clock_d = div_clock_q;
    locked_d    = locked_q;
    div_valid_d = take;
    tap_seen_d  = acc_eff;
    if (start) begin
      state_d = ST_MEASURE;
    end else if (take) begin
      state_d     = ST_MEASURE;
      div_clock_d = new_div;
      locked_d    = 1'b1;
    end else if (timeout) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end

`ifdef TAP_AVG_EN
    prev_meas_d = take ? meas : prev_meas_q;
    if (take)         have_prev_d = 1'b1;
    else if (timeout) have_prev_d = 1'b0;
    else              have_prev_d = have_prev_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      state_q       <= ST_IDLE;
      pre_cnt_q     <= '0;
      lockout_cnt_q <= '0;
      int_cnt_q     <= '0;
      div_clock_q   <= DEFAULT_DIV;
      div_valid_q   <= 1'b0;
      tap_seen_q    <= 1'b0;
      locked_q      <= 1'b0;
`ifdef TAP_AVG_EN
      prev_meas_q   <= '0;
      have_prev_q   <= 1'b0;
`endif
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      state_q       <= state_d;
      pre_cnt_q     <= pre_cnt_d;
      lockout_cnt_q <= lockout_cnt_d;
      int_cnt_q     <= int_cnt_d;
      div_clock_q   <= div_clock_d;
      div_valid_q   <= div_valid_d;
      tap_seen_q    <= tap_seen_d;
      locked_q      <= locked_d;
`ifdef TAP_AVG_EN
      prev_meas_q   <= prev_meas_d;
      have_prev_q   <= have_prev_d;
`endif
    end
  end

  assign div_clock = div_clock_q;
  assign div_valid = div_valid_q;
  assign tap_seen  = tap_seen_q;
  assign locked    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_tempo_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tap_tempo_div
//  Purpose  : Self-checking bench for tap_tempo_div. A reference model works
//             purely on tap times (cycles between rising edges) to predict
//             the divisor, lock state and pulse counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tap_tempo_div;

  localparam int PRE   = 4;
  localparam int LOCK  = 2;
  localparam int MIN   = 2;
  localparam int DEF   = 500;
  localparam int TOUT  = 4095 * PRE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tap_in = 1'b0;
  logic [11:0] div_clock;
  logic        div_valid;
  logic        tap_seen;
  logic        locked;

  tap_tempo_div #(
    .PRESCALE(PRE), .LOCKOUT_TICKS(LOCK), .MIN_DIV(12'd2), .DEFAULT_DIV(12'd500)
  ) dut (
    .clk(clk), .reset(reset), .tap_in(tap_in),
    .div_clock(div_clock), .div_valid(div_valid), .tap_seen(tap_seen), .locked(locked)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid_seen = 0;
  int n_tap_seen   = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (div_valid) n_valid_seen <= n_valid_seen + 1;
      if (tap_seen)  n_tap_seen   <= n_tap_seen + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int     m_div    = DEF;
  bit     m_meas   = 0;
  bit     m_lock   = 0;
  bit     m_havep  = 0;
  int     m_prev   = 0;
  longint m_last   = 0;
  int     m_nvalid = 0;
  int     m_nseen  = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = DEF; m_meas = 0; m_lock = 0; m_havep = 0; m_prev = 0;
  endtask

  // Rising edge of tap_in at cycle t.
  task automatic model_rise(input longint t);
    longint d;
    int     meas;
    d = t - m_last;
    if (m_meas && d > TOUT) begin
      m_meas = 0; m_lock = 0; m_havep = 0;
    end
    if (!m_meas) begin
      m_meas = 1; m_last = t; m_nseen++;
    end else if (d > LOCK * PRE) begin
      meas = int'(d / PRE);
      if (meas > 4095) meas = 4095;
      if (meas >= MIN) begin
`ifdef TAP_AVG_EN
        m_div = m_havep ? (m_prev + meas) / 2 : meas;
`else
        m_div = meas;
`endif
        m_prev = meas; m_havep = 1;
        m_lock = 1; m_last = t;
        m_nvalid++; m_nseen++;
      end
    end
  endtask

  // Apply a timeout that has certainly happened by cycle t.
  task automatic model_settle(input longint t);
    if (m_meas && (t - m_last) > TOUT + 3) begin
      m_meas = 0; m_lock = 0; m_havep = 0;
    end
  endtask

  task automatic model_check(input string tag);
    model_settle(cyc);
    chk({tag, "_div"},    div_clock,    m_div);
    chk({tag, "_locked"}, locked,       m_lock);
    chk({tag, "_nvalid"}, n_valid_seen, m_nvalid);
    chk({tag, "_nseen"},  n_tap_seen,   m_nseen);
    chk({tag, "_vpulse"}, div_valid,    0);
  endtask

  // Rise-to-next-rise distance is hold + 2 + next gap.
  task automatic press(input int gap, input int hold);
    repeat (gap) @(negedge clk);
    tap_in = 1'b1;
    model_rise(cyc);
    repeat (hold) @(negedge clk);
    tap_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g, h;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_div", div_clock, DEF);
    chk("rst_locked", locked, 0);
    chk("rst_valid", div_valid, 0);
    chk("rst_seen", tap_seen, 0);

    // Long quiet period
    repeat (20000) @(negedge clk);
    model_check("idle");

    // Two taps 400 cycles apart
    press(10, 3);
    press(395, 3);
    model_check("pair");
    chk("pair_div_const", div_clock, 100);
    chk("pair_seen_const", n_tap_seen, 2);

    // Bounce 5 cycles after a tap, then a tap 400 after the accepted one
    press(100, 3);
    press(0, 3);
    model_check("bounce");
    press(390, 3);
    model_check("after_bounce");
    chk("after_bounce_div_const", div_clock, 100);

    // Timeout: locked holds until ~16380 cycles after the last tap
    repeat (16355) @(negedge clk);
    model_check("pre_timeout");
    chk("pre_timeout_locked_const", locked, 1);
    repeat (40) @(negedge clk);
    model_check("post_timeout");
    chk("post_timeout_locked_const", locked, 0);
    chk("post_timeout_div_const", div_clock, 100);
    press(50, 3);
    model_check("tap_from_idle");

    // Two intervals: 400 then 800 cycles
    press(395, 3);
    model_check("seq1");
    press(795, 3);
    model_check("seq2");
`ifdef TAP_AVG_EN
    chk("seq2_div_const", div_clock, 150);
`else
    chk("seq2_div_const", div_clock, 200);
`endif

    // Randomized taps, including intervals around the lockout boundary
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) g = $urandom_range(0, 10);
      else                           g = $urandom_range(20, 700);
      h = $urandom_range(2, 4);
      press(g, h);
      model_check($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-measurement while locked
    press(395, 3);
    repeat (200) @(negedge clk);
    chk("pre_reset_locked", locked, m_lock);
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_div", div_clock, DEF);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_valid", div_valid, 0);
    chk("async_rst_seen", tap_seen, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Operation after reset
    press(100, 3);
    press(395, 3);
    model_check("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
